mp_feeder: RTL

MP_FEEDER -- requirements
Module: mp_feeder

---
 rtl/mp_pkg.sv | 20 ++
 rtl/mp_feeder_if.sv | 22 ++
 rtl/mp_addr_gen.sv | 96 +++++++++
 rtl/mp_feeder.sv | 110 +++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_feeder shared package: FSM state encoding, pad value, window offsets.
// Used by mp_feeder and mp_addr_gen (optional MP_FEEDER_PAD_EN build).
package mp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } mp_state_e;

    // Value emitted for out-of-range window positions: never wins a max.
    localparam logic signed [7:0] MP_MIN_VAL = 8'sh80;

    // Row / column offset of each window phase, bit index = phase.
    // Phase order: (0,0), (0,1), (1,0), (1,1).
    localparam logic [3:0] WIN_DR = 4'b1100;
    localparam logic [3:0] WIN_DC = 4'b1010;

endpackage

// File: rtl/mp_feeder_if.sv
// mp_feeder bus interface: memory read port plus pixel stream to the pool unit.
// master = feeder side, slave = memory / consumer side.
interface mp_feeder_if #(
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic signed [7:0] rd_data;
    logic signed [7:0] out;
    logic              en;
    logic              en_mp;

    modport master (
        output rd_en, rd_addr, out, en, en_mp,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, out, en, en_mp,
        output rd_data
    );
endinterface

// File: rtl/mp_addr_gen.sv
// mp_addr_gen: row/column/window-phase counters and pixel address arithmetic.
// MP_FEEDER_PAD_EN selects ceil-sized pool windows with a pad flag.
module mp_addr_gen
    import mp_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              adv,
    input  logic              pool,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              pad
);
    localparam int CW = DIM_W + 1;
    localparam int PW = 2 * DIM_W + 1;

    logic [CW-1:0]     r;
    logic [CW-1:0]     c;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  h_q;
    logic              pool_q;

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] step;
    logic [CW-1:0] span;
    logic [PW-1:0] prod;
    logic          last_col;
    logic          last_row;

    // Pixel position, address and end-of-row/end-of-map detection.
    always_comb begin
        row  = r + CW'(pool_q & WIN_DR[phase]);
        col  = c + CW'(pool_q & WIN_DC[phase]);
        step = pool_q ? CW'(2) : CW'(1);
`ifdef MP_FEEDER_PAD_EN
        span = pool_q ? CW'(2) : CW'(1);
`else
        // A full window needs both c and c+1 inside the map.
        span = pool_q ? CW'(3) : CW'(1);
`endif
        prod     = PW'(row) * PW'(w_q);
        addr     = base_q + ADDR_W'(prod) + ADDR_W'(col);
        last_col = (c + span) >= CW'(w_q);
        last_row = (r + span) >= CW'(h_q);
        last     = last_col && last_row && (!pool_q || phase == 2'd3);
`ifdef MP_FEEDER_PAD_EN
        pad = pool_q && (row >= CW'(h_q) || col >= CW'(w_q));
`else
        pad = 1'b0;
`endif
    end

    // Capture the pass configuration and step through the scan order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r      <= '0;
            c      <= '0;
            phase  <= '0;
            base_q <= '0;
            w_q    <= '0;
            h_q    <= '0;
            pool_q <= 1'b0;
        end else if (load) begin
            r      <= '0;
            c      <= '0;
            phase  <= '0;
            base_q <= base;
            w_q    <= width;
            h_q    <= height;
            pool_q <= pool;
        end else if (adv) begin
            if (!pool_q || phase == 2'd3) begin
                phase <= '0;
                if (last_col) begin
                    c <= '0;
                    r <= r + step;
                end else begin
                    c <= c + step;
                end
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end

endmodule

// File: rtl/mp_feeder.sv
// mp_feeder: reads a feature map and streams it in 2x2-window or row-major order.
// Define MP_FEEDER_PAD_EN for ceil-sized windows padded with -128.
module mp_feeder
    import mp_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pool_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  fm_width,
    input  logic [DIM_W-1:0]  fm_height,
    input  logic              stall,
    mp_feeder_if.master       bus,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] FIN   = ST_FIN;

    logic [1:0]        state;
    logic [1:0]        nxt;
    logic              pool_q;
    logic              en_q;
    logic              pad_q;
    logic              empty;
    logic              load;
    logic              slot;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              pad;

    assign load = (state == IDLE) && start;
    assign slot = (state == ISSUE) && !stall;
    assign rd   = slot && !pad && !reset;

    // A pass with no readable pixel skips straight to FIN.
    always_comb begin
`ifdef MP_FEEDER_PAD_EN
        empty = (fm_width == '0) || (fm_height == '0);
`else
        empty = (fm_width == '0) || (fm_height == '0)
             || (pool_en && (fm_width < DIM_W'(2) || fm_height < DIM_W'(2)));
`endif
    end

    mp_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .adv    (slot),
        .pool   (pool_en),
        .base   (base_addr),
        .width  (fm_width),
        .height (fm_height),
        .addr   (addr),
        .last   (last),
        .pad    (pad)
    );

    // Next-state logic of the pass sequencer.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = empty ? FIN : ISSUE;
            ISSUE:   if (slot && last) nxt = DRAIN;
            DRAIN:   nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register and one-cycle delay of the issued slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pool_q <= 1'b0;
            en_q   <= 1'b0;
            pad_q  <= 1'b0;
        end else begin
            state <= nxt;
            en_q  <= slot;
            pad_q <= slot && pad;
            if (load) pool_q <= pool_en;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        bus.rd_en   = rd;
        bus.rd_addr = rd ? addr : '0;
        bus.en      = en_q && !reset;
        bus.en_mp   = en_q && pool_q && !reset;
        if (!en_q || reset) bus.out = '0;
        else if (pad_q)     bus.out = MP_MIN_VAL;
        else                bus.out = bus.rd_data;
        busy = (state != IDLE) && !reset;
        done = (state == FIN) && !reset;
    end

endmodule
